// File: rtl/ece564_pkg.sv
// Shared widths and writer state encoding for the ece564 output path.
package ece564_pkg;

    localparam int ADDRW = 12;
    localparam int DATAW = 16;
    localparam int PIXW  = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMPTY = 2'd1;
    localparam logic [1:0] ST_HALF  = 2'd2;

    typedef enum logic [1:0] {
        WR_IDLE  = ST_IDLE,
        WR_EMPTY = ST_EMPTY,
        WR_HALF  = ST_HALF
    } writer_state_t;

endpackage

// File: rtl/output_sram_writer.sv
// Packs pairs of 8-bit ReLU results into 16-bit output SRAM words.
// Optional feature macro: OUTPUT_SRAM_WRITER_COUNT_EN adds a saturating words_written counter.
module output_sram_writer
    import ece564_pkg::*;
(
    input  logic             clk,
    input  logic             reset_b,
    input  logic             start,
    input  logic [ADDRW-1:0] base_addr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PIXW-1:0]  in_data,
    input  logic             in_last,
    output logic             output_sram_write_enable,
    output logic [ADDRW-1:0] output_sram_write_addresss,
    output logic [DATAW-1:0] output_sram_write_data,
    output logic             busy,
    output logic             done
`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
    ,
    output logic [15:0]      words_written
`endif
);

    writer_state_t    state;
    logic [ADDRW-1:0] ptr;
    logic [PIXW-1:0]  low_byte;

    logic             xfer;
    logic             start_ok;
    logic             write_now;
    logic [DATAW-1:0] next_data;

    assign in_ready  = (state != WR_IDLE);
    assign xfer      = in_valid & in_ready;
    assign start_ok  = start && (state == WR_IDLE);
    // A word completes on the second byte, or early when the last result lands alone.
    assign write_now = xfer && ((state == WR_HALF) || in_last);
    assign next_data = (state == WR_HALF) ? {in_data, low_byte} : {PIXW'(0), in_data};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state    <= WR_IDLE;
            ptr      <= '0;
            low_byte <= '0;
        end else begin
            case (state)
                WR_IDLE: begin
                    if (start) begin
                        state <= WR_EMPTY;
                        ptr   <= base_addr;
                    end
                end
                WR_EMPTY: begin
                    if (xfer) begin
                        if (in_last) begin
                            state <= WR_IDLE;
                            ptr   <= ptr + ADDRW'(1);
                        end else begin
                            low_byte <= in_data;
                            state    <= WR_HALF;
                        end
                    end
                end
                WR_HALF: begin
                    if (xfer) begin
                        state <= in_last ? WR_IDLE : WR_EMPTY;
                        ptr   <= ptr + ADDRW'(1);
                    end
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    // Address and data only update on a write so they hold while the strobe is low.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            output_sram_write_enable   <= 1'b0;
            output_sram_write_addresss <= '0;
            output_sram_write_data     <= '0;
            done                       <= 1'b0;
            busy                       <= 1'b0;
        end else begin
            output_sram_write_enable <= write_now;
            done                     <= write_now && in_last;
            if (write_now) begin
                output_sram_write_addresss <= ptr;
                output_sram_write_data     <= next_data;
            end
            // A start accepted in the done cycle keeps busy asserted.
            if (start_ok) begin
                busy <= 1'b1;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end

`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            words_written <= '0;
        end else if (start_ok) begin
            words_written <= '0;
        end else if (write_now && (words_written != 16'hFFFF)) begin
            words_written <= words_written + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_output_sram_writer.sv
// Directed bench for output_sram_writer; honours OUTPUT_SRAM_WRITER_COUNT_EN when defined.
module tb_output_sram_writer;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic        we;
    logic [11:0] waddr;
    logic [15:0] wdata;
    logic        busy;
    logic        done;
`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
    logic [15:0] words_written;
`endif

    int total = 0;
    int passed = 0;
    int stray_done = 0;

    logic [11:0] wa_q[$];
    logic [15:0] wd_q[$];
    logic        wdn_q[$];

    output_sram_writer dut (
        .clk(clk),
        .reset_b(reset_b),
        .start(start),
        .base_addr(base_addr),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_last(in_last),
        .output_sram_write_enable(we),
        .output_sram_write_addresss(waddr),
        .output_sram_write_data(wdata),
        .busy(busy),
        .done(done)
`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
        ,
        .words_written(words_written)
`endif
    );

    always #5 clk = ~clk;

    // Log every presented write away from the active edge.
    always @(negedge clk) begin
        if (reset_b) begin
            if (we === 1'b1) begin
                wa_q.push_back(waddr);
                wd_q.push_back(wdata);
                wdn_q.push_back(done);
            end else if (done === 1'b1) begin
                stray_done++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic drive(input logic s, input logic [11:0] ba, input logic v,
                         input logic [7:0] d, input logic l);
        @(negedge clk);
        start = s; base_addr = ba; in_valid = v; in_data = d; in_last = l;
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); wdn_q.delete();
    endtask

    task automatic test_reset();
        reset_b = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (we !== 1'b0) $display("FAIL reset_we: got %b want 0", we); else passed++;
        total++; if (waddr !== 12'h000) $display("FAIL reset_addr: got %h want 000", waddr); else passed++;
        total++; if (wdata !== 16'h0000) $display("FAIL reset_data: got %h want 0000", wdata); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", in_ready); else passed++;
        @(negedge clk);
        reset_b = 1'b1;
    endtask

    task automatic test_basic();
        drive(1'b1, 12'h100, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h11, 1'b0);
        total++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL basic_ready: got %b want 1", in_ready); else passed++;
        drive(1'b0, 12'h000, 1'b1, 8'h22, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h33, 1'b0);
        total++; if ({we, waddr, wdata, done} !== {1'b1, 12'h100, 16'h2211, 1'b0})
            $display("FAIL basic_w0: got we=%b %h@%h done=%b want 1 2211@100 0", we, wdata, waddr, done); else passed++;
        drive(1'b0, 12'h000, 1'b1, 8'h44, 1'b1);
        total++; if (we !== 1'b0) $display("FAIL basic_we_pulse: got %b want 0", we); else passed++;
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if ({we, waddr, wdata, done, busy} !== {1'b1, 12'h101, 16'h4433, 1'b1, 1'b1})
            $display("FAIL basic_w1: got we=%b %h@%h done=%b busy=%b want 1 4433@101 1 1", we, wdata, waddr, done, busy); else passed++;
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if ({we, done, busy, in_ready} !== 4'b0000)
            $display("FAIL basic_after: got we/done/busy/ready=%b%b%b%b want 0000", we, done, busy, in_ready); else passed++;
        total++; if ({waddr, wdata} !== {12'h101, 16'h4433})
            $display("FAIL basic_hold: got %h@%h want 4433@101", wdata, waddr); else passed++;
    endtask

    task automatic test_odd();
        logic [11:0] ea[2];
        logic [15:0] ed[2];
        logic        edn[2];
        ea = '{12'h020, 12'h021}; ed = '{16'h0605, 16'h0007}; edn = '{1'b0, 1'b1};
        clear_log();
        drive(1'b1, 12'h020, 1'b1, 8'hAA, 1'b1);
        drive(1'b0, 12'h000, 1'b1, 8'h05, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h06, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h07, 1'b1);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 2) $display("FAIL odd_count: got %0d writes want 2", wa_q.size()); else passed++;
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || wdn_q[i] !== edn[i])
                $display("FAIL odd_w%0d: got %h@%h done=%b want %h@%h done=%b", i, wd_q[i], wa_q[i], wdn_q[i], ed[i], ea[i], edn[i]);
            else passed++;
        end
        total++; if (busy !== 1'b0) $display("FAIL odd_busy: got %b want 0", busy); else passed++;
`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
        total++; if (words_written !== 16'd2) $display("FAIL odd_words: got %0d want 2", words_written); else passed++;
`endif
    endtask

    task automatic test_wrap();
        logic [11:0] ea[2];
        logic [15:0] ed[2];
        ea = '{12'hFFF, 12'h000}; ed = '{16'h007F, 16'hFF80};
        clear_log();
        drive(1'b1, 12'hFFF, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h7F, 1'b0);
`ifdef OUTPUT_SRAM_WRITER_COUNT_EN
        total++; if (words_written !== 16'd0) $display("FAIL wrap_words_clear: got %0d want 0", words_written); else passed++;
`endif
        drive(1'b0, 12'h000, 1'b1, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h80, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'hFF, 1'b1);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 2) $display("FAIL wrap_count: got %0d writes want 2", wa_q.size()); else passed++;
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
                $display("FAIL wrap_w%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], ed[i], ea[i]);
            else passed++;
        end
    endtask

    task automatic test_start_in_half();
        logic [11:0] ea[2];
        logic [15:0] ed[2];
        ea = '{12'h300, 12'h301}; ed = '{16'h3412, 16'h7856};
        clear_log();
        drive(1'b1, 12'h300, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h12, 1'b0);
        drive(1'b1, 12'h555, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h34, 1'b0);
        drive(1'b1, 12'h666, 1'b1, 8'h56, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h78, 1'b1);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 2) $display("FAIL half_start_count: got %0d writes want 2", wa_q.size()); else passed++;
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i])
                $display("FAIL half_start_w%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], ed[i], ea[i]);
            else passed++;
        end
    endtask

    task automatic test_reset_in_half();
        clear_log();
        drive(1'b1, 12'h400, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h9A, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        reset_b = 1'b0;
        #1;
        total++; if ({we, waddr, wdata, busy, done, in_ready} !== 32'h0)
            $display("FAIL rst_half_outputs: got we=%b %h@%h busy=%b done=%b ready=%b want all 0", we, wdata, waddr, busy, done, in_ready); else passed++;
        @(negedge clk);
        reset_b = 1'b1;
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 0) $display("FAIL rst_half_nowrite: got %0d writes want 0", wa_q.size()); else passed++;
        drive(1'b1, 12'h050, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h01, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h02, 1'b1);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 1) $display("FAIL rst_half_count: got %0d writes want 1", wa_q.size()); else passed++;
        if (wa_q.size() > 0) begin
            total++;
            if (wa_q[0] !== 12'h050 || wd_q[0] !== 16'h0201 || wdn_q[0] !== 1'b1)
                $display("FAIL rst_half_w0: got %h@%h done=%b want 0201@050 done=1", wd_q[0], wa_q[0], wdn_q[0]);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ea[2];
        logic [15:0] ed[2];
        ea = '{12'h010, 12'h011}; ed = '{16'h000A, 16'h0C0B};
        clear_log();
        drive(1'b1, 12'h010, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b1, 8'h0A, 1'b1);
        drive(1'b1, 12'h011, 1'b0, 8'h00, 1'b0);
        total++; if ({we, done} !== 2'b11) $display("FAIL b2b_done: got we=%b done=%b want 1 1", we, done); else passed++;
        drive(1'b0, 12'h000, 1'b1, 8'h0B, 1'b0);
        total++; if ({busy, in_ready} !== 2'b11) $display("FAIL b2b_busy: got busy=%b ready=%b want 1 1", busy, in_ready); else passed++;
        drive(1'b0, 12'h000, 1'b1, 8'h0C, 1'b1);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 12'h000, 1'b0, 8'h00, 1'b0);
        total++; if (wa_q.size() != 2) $display("FAIL b2b_count: got %0d writes want 2", wa_q.size()); else passed++;
        for (int i = 0; i < 2 && i < wa_q.size(); i++) begin
            total++;
            if (wa_q[i] !== ea[i] || wd_q[i] !== ed[i] || wdn_q[i] !== 1'b1)
                $display("FAIL b2b_w%0d: got %h@%h done=%b want %h@%h done=1", i, wd_q[i], wa_q[i], wdn_q[i], ed[i], ea[i]);
            else passed++;
        end
        total++; if (stray_done != 0) $display("FAIL stray_done: got %0d want 0", stray_done); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_odd();
        test_wrap();
        test_start_in_half();
        test_reset_in_half();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/output_sram_writer.md
OUTPUT_SRAM_WRITER -- requirements
Module: output_sram_writer

Interface
REQ-001 SHALL have a single clock, clk; reset is reset_b, asynchronous, active-low.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_b  input  1  asynchronous active-low reset.
REQ-004 Port: start  input  1  one-cycle pulse; arms the block for one output matrix.
REQ-005 Port: base_addr  input  12  first output SRAM word address, sampled on accepted start.
REQ-006 Port: in_valid  input  1  upstream ReLU result valid.
REQ-007 Port: in_ready  output  1  block can accept a result this cycle.
REQ-008 Port: in_data  input  8  ReLU result, unsigned 0..127.
REQ-009 Port: in_last  input  1  qualifies in_data as the final result of the matrix.
REQ-010 Port: output_sram_write_enable  output  1  write strobe.
REQ-011 Port: output_sram_write_addresss  output  12  write word address.
REQ-012 Port: output_sram_write_data  output  16  packed write data.
REQ-013 Port: busy  output  1  high from accepted start until the final write completes.
REQ-014 Port: done  output  1  one-cycle pulse in the cycle the final write is presented.

Function
REQ-015 SHALL implement states IDLE, EMPTY and HALF.
REQ-016 IDLE: in_ready=0; start moves to EMPTY, loads the address pointer from base_addr and sets busy.
REQ-017 EMPTY/HALF: in_ready=1; a transfer occurs when in_valid & in_ready.
REQ-018 EMPTY, transfer without in_last: latch in_data as the low byte and go to HALF.
REQ-019 HALF, transfer: write {in_data, low byte} (first result in [7:0]), increment the pointer, and return to EMPTY, or to IDLE if in_last.
REQ-020 EMPTY, transfer with in_last: write {8'h00, in_data}, increment the pointer, and go to IDLE.
REQ-021 Write outputs SHALL be registered: the write is presented exactly one cycle after the completing transfer, with write_enable high for exactly one cycle.
REQ-022 done SHALL pulse in the same cycle as the final write; busy SHALL fall in the cycle after it.
REQ-023 write_enable low => write address/data hold their last values (not X).
REQ-024 start while not in IDLE SHALL be ignored.
REQ-025 start and in_valid in the same IDLE cycle: only start takes effect, because in_ready=0.
REQ-026 The address pointer SHALL wrap from 0xFFF to 0x000 without error.
REQ-027 in_data bits are written verbatim; the block SHALL NOT saturate or clip.

Reset
REQ-028 On reset_b low: state=IDLE, pointer=0, low byte=0, write_enable=0, write address=0, write data=0, busy=0, done=0, in_ready=0.
REQ-029 Reset mid-matrix SHALL discard any held half word without writing it.

Configuration
REQ-030 Macro OUTPUT_SRAM_WRITER_COUNT_EN defined: add output port words_written (16 bits), cleared on reset and on accepted start, incremented on every write, saturating at 0xFFFF.
REQ-031 Macro OUTPUT_SRAM_WRITER_COUNT_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package ece564_pkg SHALL hold ADDRW=12, DATAW=16, PIXW=8 and the writer state enum typedef.
REQ-033 Single flat module; no sub-module.

Verification
REQ-034 Reset, start base_addr=0x100, 4 results 0x11,0x22,0x33,0x44(last) -> writes 0x2211@0x100 and 0x4433@0x101; done coincides with the second write.
REQ-035 Odd count: start base_addr=0x020, results 0x05,0x06,0x07(last) -> 0x0605@0x020, then 0x0007@0x021.
REQ-036 Wrap: base_addr=0xFFF, 4 results -> writes at 0xFFF, then 0x000.
REQ-037 start pulsed while in HALF -> ignored; pointer and held byte unchanged; results continue to pack correctly.
REQ-038 reset_b asserted in HALF -> no write, all outputs 0; a new start then writes from the new base_addr.
REQ-039 With OUTPUT_SRAM_WRITER_COUNT_EN, 3 results (last on 3rd) -> words_written=2; a following start -> 0.
